bicubic_scan_sched: RTL and testbench

Sequencing controller for the bicubic scaler's weight datapath. For each output pixel of a frame it walks fixed-point phase accumulators in x and y, then presents an integer source coordinate and a 9-bit fractional blend (1.0 = 256) to the per-tap weight units (x0..x3, y0..y3). Those units have no enable or stall. This block therefore issues one coordinate per accepted handshake and tracks a latency-matched valid tag, so the downstream pixel mixer knows which weight-unit outputs are real. It sits between the frame-level control registers and the weight/mix pipeline.

---
 rtl/bicubic_pkg.sv | 30 +++
 rtl/bicubic_scan_sched_if.sv | 28 ++
 rtl/phase_acc.sv | 41 ++++
 rtl/bicubic_scan_sched.sv | 120 ++++++++++++
 tb/tb_bicubic_scan_sched.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bicubic_pkg.sv
// Shared types, widths and helpers for the bicubic scan scheduler.
package bicubic_pkg;

  localparam int unsigned CW        = 11;
  localparam int unsigned WGT_LAT   = 6;
  localparam int unsigned STEP_W    = 16;
  localparam int unsigned ACC_W     = 27;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned BLEND_W   = 9;

  localparam logic [BLEND_W-1:0] COEFF_ONE  = 9'd256;
  localparam logic [BLEND_W-1:0] COEFF_HALF = 9'd128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

  // Frame configuration captured on start
  typedef struct packed {
    logic [CW-1:0]     out_w;
    logic [CW-1:0]     out_h;
    logic [STEP_W-1:0] step_x;
    logic [STEP_W-1:0] step_y;
  } cfg_t;

  // Integer part of an accumulator, clamped to the largest coordinate
  function automatic logic [CW-1:0] sat_coord(input logic [ACC_W-1:0] acc);
    if (|acc[ACC_W-1:FRAC_BITS+CW]) return '1;
    return acc[FRAC_BITS+CW-1:FRAC_BITS];
  endfunction

endpackage

// File: rtl/bicubic_scan_sched_if.sv
// Coordinate channel from the scheduler to the weight units / pixel mixer.
//   coord_valid/coord_ready : handshake
//   src_x/src_y, x_blend/y_blend, line_last/frame_last : payload
//   wgt_valid : latency-matched tag for the weight-unit outputs
interface bicubic_scan_sched_if;
  import bicubic_pkg::*;

  logic               coord_valid;
  logic               coord_ready;
  logic [CW-1:0]      src_x;
  logic [CW-1:0]      src_y;
  logic [BLEND_W-1:0] x_blend;
  logic [BLEND_W-1:0] y_blend;
  logic               line_last;
  logic               frame_last;
  logic               wgt_valid;

  modport master (
    output coord_valid, src_x, src_y, x_blend, y_blend, line_last, frame_last, wgt_valid,
    input  coord_ready
  );

  modport slave (
    input  coord_valid, src_x, src_y, x_blend, y_blend, line_last, frame_last, wgt_valid,
    output coord_ready
  );

endinterface

// File: rtl/phase_acc.sv
// Q19.8 phase accumulator with clear and step-add; registered saturated
// integer coordinate and 9-bit blend fraction.
//   clr   : zero the accumulator (wins over add)
//   add   : acc += step
//   coord : saturated integer part, blend : {0, fraction}
module phase_acc
  import bicubic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               add,
  input  logic [STEP_W-1:0]  step,
  output logic [CW-1:0]      coord,
  output logic [BLEND_W-1:0] blend
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;

  // Next accumulator value
  always_comb begin
    acc_nxt = acc;
    if (clr)      acc_nxt = '0;
    else if (add) acc_nxt = acc + ACC_W'(step);
  end

  // Outputs are registered from the next value so they align with acc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      coord <= '0;
      blend <= '0;
    end else begin
      acc   <= acc_nxt;
      coord <= sat_coord(acc_nxt);
      blend <= {1'b0, acc_nxt[FRAC_BITS-1:0]};
    end
  end

endmodule

// File: rtl/bicubic_scan_sched.sv
// Output-pixel scan sequencer for the bicubic weight datapath.
//   start, cfg_*  : frame start pulse and frame config (captured at start)
//   cif (master)  : coordinate handshake, payload and wgt_valid tag
//   busy, done    : frame in progress / frame complete and pipe drained
module bicubic_scan_sched
  import bicubic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     cfg_out_w,
  input  logic [CW-1:0]     cfg_out_h,
  input  logic [STEP_W-1:0] cfg_step_x,
  input  logic [STEP_W-1:0] cfg_step_y,
  bicubic_scan_sched_if.master cif,
  output logic              busy,
  output logic              done
);

  state_e             state, state_nxt;
  cfg_t               cfg_q;
  logic [CW-1:0]      px_cnt, ln_cnt, px_nxt, ln_nxt;
  logic [CW-1:0]      w_sel, h_sel;
  logic [WGT_LAT-1:0] tag;
  logic               start_go, fire, line_end, run_nxt, ll_nxt, fl_nxt;
  logic [CW-1:0]      x_src, y_src;
  logic [BLEND_W-1:0] x_bl, y_bl;

  // Next state, counters and coordinate qualifiers
  always_comb begin
    state_nxt = state;
    start_go  = (state == IDLE) && start;
    fire      = cif.coord_valid && cif.coord_ready;
    line_end  = fire && cif.line_last;
    px_nxt    = px_cnt;
    ln_nxt    = ln_cnt;
    // The start cycle qualifies against the live config, not the stale copy
    w_sel     = start_go ? cfg_out_w : cfg_q.out_w;
    h_sel     = start_go ? cfg_out_h : cfg_q.out_h;

    case (state)
      IDLE:    if (start) state_nxt = (cfg_out_w == '0 || cfg_out_h == '0) ? FIN : RUN;
      RUN:     if (fire && cif.frame_last) state_nxt = DRAIN;
      // Leave when the tag pipe will be empty after this shift
      DRAIN:   if (tag[WGT_LAT-2:0] == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (start_go) begin
      px_nxt = '0;
      ln_nxt = '0;
    end else if (line_end) begin
      px_nxt = '0;
      ln_nxt = ln_cnt + CW'(1);
    end else if (fire) begin
      px_nxt = px_cnt + CW'(1);
    end

    run_nxt = (state_nxt == RUN);
    ll_nxt  = run_nxt && (px_nxt == w_sel - CW'(1));
    fl_nxt  = ll_nxt && (ln_nxt == h_sel - CW'(1));
  end

  // State, counters, tag pipe and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cfg_q          <= '0;
      px_cnt         <= '0;
      ln_cnt         <= '0;
      tag            <= '0;
      cif.coord_valid <= 1'b0;
      cif.line_last  <= 1'b0;
      cif.frame_last <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      px_cnt         <= px_nxt;
      ln_cnt         <= ln_nxt;
      tag            <= {tag[WGT_LAT-2:0], fire};
      if (start_go) cfg_q <= '{out_w: cfg_out_w, out_h: cfg_out_h,
                               step_x: cfg_step_x, step_y: cfg_step_y};
      cif.coord_valid <= run_nxt;
      cif.line_last  <= ll_nxt;
      cif.frame_last <= fl_nxt;
      busy           <= (state_nxt != IDLE);
      done           <= (state_nxt == FIN);
    end
  end

  // x restarts every line; y advances once per line
  phase_acc u_acc_x (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go || line_end),
    .add   (fire),
    .step  (cfg_q.step_x),
    .coord (x_src),
    .blend (x_bl)
  );

  phase_acc u_acc_y (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go),
    .add   (line_end),
    .step  (cfg_q.step_y),
    .coord (y_src),
    .blend (y_bl)
  );

  assign cif.src_x     = x_src;
  assign cif.src_y     = y_src;
  assign cif.x_blend   = x_bl;
  assign cif.y_blend   = y_bl;
  assign cif.wgt_valid = tag[WGT_LAT-1];

endmodule

// File: tb/tb_bicubic_scan_sched.sv
// Self-checking bench for bicubic_scan_sched: reset, coordinate tables,
// frame-level timing table and randomized frames against a scan model.
module tb_bicubic_scan_sched;
  import bicubic_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CW-1:0]     cfg_out_w, cfg_out_h;
  logic [STEP_W-1:0] cfg_step_x, cfg_step_y;
  logic              busy, done;

  int checks;
  int errors;

  bicubic_scan_sched_if cif();

  bicubic_scan_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_out_w  (cfg_out_w),
    .cfg_out_h  (cfg_out_h),
    .cfg_step_x (cfg_step_x),
    .cfg_step_y (cfg_step_y),
    .cif        (cif),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic chk_zero(input string name);
    chk({name, "_coord_valid"}, 32'(cif.coord_valid), 0);
    chk({name, "_src_x"},       32'(cif.src_x), 0);
    chk({name, "_src_y"},       32'(cif.src_y), 0);
    chk({name, "_x_blend"},     32'(cif.x_blend), 0);
    chk({name, "_y_blend"},     32'(cif.y_blend), 0);
    chk({name, "_line_last"},   32'(cif.line_last), 0);
    chk({name, "_frame_last"},  32'(cif.frame_last), 0);
    chk({name, "_wgt_valid"},   32'(cif.wgt_valid), 0);
    chk({name, "_busy"},        32'(busy), 0);
    chk({name, "_done"},        32'(done), 0);
  endtask

  // Raster-order scan model: pixel k sits at column k%w, row k/w
  function automatic void model(input int w, input int h, input int sx, input int sy, input int k,
                                output int ex, output int exb, output int ey, output int eyb,
                                output int ell, output int efl);
    longint ax, ay;
    longint cmax;
    int i, j;
    cmax = (longint'(1) << CW) - 1;
    i = k % w;
    j = k / w;
    ax = longint'(i) * longint'(sx);
    ay = longint'(j) * longint'(sy);
    ex  = int'(((ax >> 8) > cmax) ? cmax : (ax >> 8));
    ey  = int'(((ay >> 8) > cmax) ? cmax : (ay >> 8));
    exb = int'(ax % 256);
    eyb = int'(ay % 256);
    ell = (i == w - 1) ? 1 : 0;
    efl = (ell == 1 && j == h - 1) ? 1 : 0;
  endfunction

  // Runs one frame from IDLE; checks every cycle until busy has dropped.
  // done_t is the cycle offset of done relative to the start cycle.
  task automatic run_frame(input int w, input int h, input int sx, input int sy,
                           input int rdy_pct, input int stall_k, input bit poke,
                           output int done_t);
    int n, k, last, stall, limit;
    int ex, exb, ey, eyb, ell, efl;
    bit exp_valid, exp_done, exp_busy, rdy;
    bit fired[int];
    n = w * h; k = 0; last = -1; stall = 0; done_t = -1;
    limit = n * 30 + 60;
    start = 1'b1;
    cfg_out_w = CW'(w); cfg_out_h = CW'(h);
    cfg_step_x = STEP_W'(sx); cfg_step_y = STEP_W'(sy);
    cif.coord_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_out_w = CW'($urandom); cfg_out_h = CW'($urandom);
    cfg_step_x = STEP_W'($urandom); cfg_step_y = STEP_W'($urandom);
    for (int t = 1; t <= limit; t++) begin
      exp_valid = (k < n);
      chk("coord_valid", 32'(cif.coord_valid), 32'(exp_valid));
      if (exp_valid) begin
        model(w, h, sx, sy, k, ex, exb, ey, eyb, ell, efl);
        chk("src_x",      32'(cif.src_x), 32'(ex));
        chk("x_blend",    32'(cif.x_blend), 32'(exb));
        chk("src_y",      32'(cif.src_y), 32'(ey));
        chk("y_blend",    32'(cif.y_blend), 32'(eyb));
        chk("line_last",  32'(cif.line_last), 32'(ell));
        chk("frame_last", 32'(cif.frame_last), 32'(efl));
      end
      chk("wgt_valid", 32'(cif.wgt_valid), 32'(fired.exists(t - int'(WGT_LAT))));
      exp_done = (n == 0) ? (t == 1) : (k == n && t == last + int'(WGT_LAT) + 1);
      exp_busy = (n == 0) ? (t <= 1) : !(k == n && t > last + int'(WGT_LAT) + 1);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_done) done_t = t;
      if (done_t >= 0 && t == done_t + 1) break;
      // A second start while running must be ignored
      if (poke && t == 3) begin
        start = 1'b1; cfg_out_w = '0; cfg_out_h = CW'(1);
      end else begin
        start = 1'b0;
      end
      if (stall_k >= 0 && k == stall_k && exp_valid && stall < 3) begin
        rdy = 1'b0; stall++;
      end else begin
        rdy = ($urandom_range(99) < rdy_pct);
      end
      cif.coord_ready = rdy;
      if (exp_valid && rdy) begin
        fired[t] = 1'b1; last = t; k++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("frame_completed", 32'(done_t >= 0), 1);
  endtask

  typedef struct {
    int sx, xb, sy, yb, ll, fl;
  } coord_vec_t;

  typedef struct {
    int w, h, sx, sy, rdy, stall_k;
    bit poke;
    int exp_done;
  } frame_vec_t;

  coord_vec_t tv[4];
  frame_vec_t fv[7];
  int dt;

  initial begin
    checks = 0; errors = 0;
    tv[0] = '{0, 0,   0, 0,   0, 0};
    tv[1] = '{1, 128, 0, 0,   1, 0};
    tv[2] = '{0, 0,   1, 128, 0, 0};
    tv[3] = '{1, 128, 1, 128, 1, 1};
    //         w     h  sx       sy       rdy  stall poke done
    fv[0] = '{2,    2, 'h0180, 'h0180, 100, -1,   0,   11};
    fv[1] = '{2,    2, 'h0180, 'h0180, 100,  1,   0,   14};
    fv[2] = '{1,    1, 'h0100, 'h0100, 100, -1,   0,   8};
    fv[3] = '{0,    3, 'h0100, 'h0100, 100, -1,   0,   1};
    fv[4] = '{3,    0, 'h0100, 'h0100, 100, -1,   0,   1};
    fv[5] = '{4,    3, 'h0155, 'h00C0, 100, -1,   1,   19};
    fv[6] = '{2047, 1, 'hFFFF, 'h0100, 100, -1,   0,   2054};

    rst_n = 1'b0; start = 1'b0; cif.coord_ready = 1'b0;
    cfg_out_w = '0; cfg_out_h = '0; cfg_step_x = '0; cfg_step_y = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1 chk_zero("idle");

    // Reset in the middle of a frame after three accepted coordinates
    start = 1'b1; cfg_out_w = CW'(4); cfg_out_h = CW'(4);
    cfg_step_x = 16'h0100; cfg_step_y = 16'h0100; cif.coord_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk); #1 chk_zero("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_wgt_valid", 32'(cif.wgt_valid), 0);
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_valid", 32'(cif.coord_valid), 0);
    end

    // 2x2 frame with step 1.5: coordinate table, consecutive cycles
    start = 1'b1; cfg_out_w = CW'(2); cfg_out_h = CW'(2);
    cfg_step_x = 16'h0180; cfg_step_y = 16'h0180; cif.coord_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tv_valid", 32'(cif.coord_valid), 1);
      chk("tv_src_x", 32'(cif.src_x), 32'(tv[i].sx));
      chk("tv_x_blend", 32'(cif.x_blend), 32'(tv[i].xb));
      chk("tv_src_y", 32'(cif.src_y), 32'(tv[i].sy));
      chk("tv_y_blend", 32'(cif.y_blend), 32'(tv[i].yb));
      chk("tv_line_last", 32'(cif.line_last), 32'(tv[i].ll));
      chk("tv_frame_last", 32'(cif.frame_last), 32'(tv[i].fl));
      @(posedge clk); #1;
    end
    chk("tv_valid_after", 32'(cif.coord_valid), 0);
    chk("tv_half_blend", 32'(tv[1].xb), 32'(COEFF_HALF));
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("tv_idle", 32'(busy), 0);

    // Frame-level timing table
    for (int i = 0; i < 7; i++) begin
      run_frame(fv[i].w, fv[i].h, fv[i].sx, fv[i].sy, fv[i].rdy, fv[i].stall_k,
                fv[i].poke, dt);
      chk("done_cycle", 32'(dt), 32'(fv[i].exp_done));
      @(posedge clk); #1;
    end

    // Randomized frames with random backpressure
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)),
                int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 16'hFFFF)),
                70, -1, (i % 2) == 1, dt);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
